// File: rtl/vga_scan_mixer.sv
// vga_scan_mixer: VGA 640x480 timing generator and sprite/background colour
// mixer. The 50 MHz clock is split into two-clock pixel periods; counters
// hold steady across both clocks so sprite renderers can register their
// outputs at the end of phase 0, and the mixer samples them at the end of
// phase 1 (pix_tick). Every video output is therefore one pixel period
// (2 clocks) behind the counter value that produced it.
//
// There is no valid/ready handshake here. Sprite inputs are free-running
// levels and are sampled only on pix_tick clocks.
module vga_scan_mixer #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int NUM_SPRITES = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_SPRITES-1:0]   spr_data,
    input  logic [8*NUM_SPRITES-1:0] spr_rgb,
    input  logic [7:0]               bg_rgb,
    input  logic                     crash_clr,
    output logic [9:0]               hcount,
    output logic [9:0]               vcount,
    output logic                     pix_tick,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     video_on,
    output logic [2:0]               red,
    output logic [2:0]               green,
    output logic [1:0]               blue,
    output logic                     frame_start,
    output logic                     collision,
    output logic                     crash
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Timing state
    logic       phase_q;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       frame_wrap;

    // Combinational decode of the current counter position
    logic       hs_raw;
    logic       vs_raw;
    logic       vis;
    logic [7:0] sel_rgb;
    logic       others_on;

    // Registered video outputs
    logic       hsync_q;
    logic       vsync_q;
    logic       video_on_q;
    logic [7:0] rgb_q;
    logic       collision_q;
    logic       crash_q, crash_d;
    logic       frame_start_q;

    // Next counter position: advance one pixel on the last clock of each pixel period
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        frame_wrap = 1'b0;
        if (phase_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Sync/visible decode and colour priority: lowest-index active sprite wins
    always_comb begin
        hs_raw  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vs_raw  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        vis     = (h_q < H_VIS) && (v_q < V_VIS);
        sel_rgb = bg_rgb;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (spr_data[i]) begin
                sel_rgb = spr_rgb[8*i +: 8];
            end
        end
        if (!vis) begin
            sel_rgb = '0;
        end
        others_on = |spr_data[NUM_SPRITES-1:1];
    end

    // Sticky crash: a registered collision sets it and takes priority over a clear
    always_comb begin
        crash_d = collision_q | (crash_q & ~crash_clr);
    end

    // Timing and output registers; video outputs only load on pix_tick clocks
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q       <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            rgb_q         <= '0;
            collision_q   <= 1'b0;
            crash_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= ~phase_q;
            h_q           <= h_d;
            v_q           <= v_d;
            crash_q       <= crash_d;
            frame_start_q <= frame_wrap;
            if (phase_q) begin
                hsync_q     <= hs_raw;
                vsync_q     <= vs_raw;
                video_on_q  <= vis;
                rgb_q       <= sel_rgb;
                collision_q <= vis & spr_data[0] & others_on;
            end
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign pix_tick    = phase_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign frame_start = frame_start_q;
    assign collision   = collision_q;
    assign crash       = crash_q;

endmodule

// File: tb/tb_vga_scan_mixer.sv
// tb_vga_scan_mixer: randomized sprite/background stimulus against a model
// that derives every expected output from the number of clocks since reset
// was released (pixel index = clocks/2, position = pixel index modulo the
// line and frame sizes). A reduced screen geometry keeps frames short.
module tb_vga_scan_mixer;

    localparam int HV = 40, HF = 4, HS = 8, HB = 8;
    localparam int VV = 20, VF = 2, VS = 2, VB = 3;
    localparam int NS = 8;
    localparam int HT = HV + HF + HS + HB;   // 60
    localparam int VT = VV + VF + VS + VB;   // 27

    // Clock / reset and DUT signals
    logic            clock = 1'b0;
    logic            reset_n;
    logic [NS-1:0]   spr_data;
    logic [8*NS-1:0] spr_rgb;
    logic [7:0]      bg_rgb;
    logic            crash_clr;
    logic [9:0]      hcount, vcount;
    logic            pix_tick, hsync, vsync, video_on;
    logic [2:0]      red, green;
    logic [1:0]      blue;
    logic            frame_start, collision, crash;

    always #10 clock = ~clock;

    vga_scan_mixer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .NUM_SPRITES(NS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .spr_data(spr_data), .spr_rgb(spr_rgb),
        .bg_rgb(bg_rgb), .crash_clr(crash_clr), .hcount(hcount), .vcount(vcount),
        .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start),
        .collision(collision), .crash(crash)
    );

    // Scoreboard state
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         n_clk;      // clock edges since reset released
    logic       exp_hs, exp_vs, exp_vid, exp_col, exp_crash, exp_fs;
    logic [7:0] exp_rgb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (clk %0d, t=%0t)", tag, obs, exp, n_clk, $time);
        end
    endtask

    task automatic drive_random();
        spr_data  = ($urandom_range(0, 3) == 0) ? '0 : NS'($urandom & $urandom & $urandom);
        spr_rgb   = {$urandom, $urandom};
        bg_rgb    = 8'($urandom);
        crash_clr = ($urandom_range(0, 7) == 0);
    endtask

    // Apply one clock edge to the model, using the inputs present before the edge
    task automatic model_edge();
        int   p, h, v;
        logic vis, others;
        logic new_crash;
        if (!reset_n) begin
            n_clk     = 0;
            exp_hs    = 1'b1;
            exp_vs    = 1'b1;
            exp_vid   = 1'b0;
            exp_rgb   = '0;
            exp_col   = 1'b0;
            exp_crash = 1'b0;
            exp_fs    = 1'b0;
        end else begin
            new_crash = exp_col | (exp_crash & !crash_clr);
            n_clk++;
            exp_fs = 1'b0;
            if (n_clk % 2 == 0) begin
                // Sample edge: position shown is the pixel that just ended
                p       = (n_clk - 2) / 2;
                h       = p % HT;
                v       = (p / HT) % VT;
                vis     = (h < HV) && (v < VV);
                exp_hs  = !(h >= HV + HF && h < HV + HF + HS);
                exp_vs  = !(v >= VV + VF && v < VV + VF + VS);
                exp_vid = vis;
                exp_rgb = bg_rgb;
                for (int i = 0; i < NS; i++) begin
                    if (spr_data[i]) begin
                        exp_rgb = spr_rgb[8*i +: 8];
                        break;
                    end
                end
                if (!vis) exp_rgb = '0;
                others  = 1'b0;
                for (int i = 1; i < NS; i++) others |= spr_data[i];
                exp_col = vis && spr_data[0] && others;
                exp_fs  = ((n_clk / 2) % (HT * VT)) == 0;
            end
            exp_crash = new_crash;
        end
    endtask

    task automatic check_outputs();
        int p;
        p = n_clk / 2;
        check("hcount", 32'(hcount), 32'(p % HT));
        check("vcount", 32'(vcount), 32'((p / HT) % VT));
        check("pix_tick", 32'(pix_tick), 32'(n_clk % 2));
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));
        check("video_on", 32'(video_on), 32'(exp_vid));
        check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        check("collision", 32'(collision), 32'(exp_col));
        check("crash", 32'(crash), 32'(exp_crash));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    // One clock: drive inputs, edge, model, check on the falling edge
    task automatic step(input logic rst_n_val);
        reset_n = rst_n_val;
        drive_random();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    int hs_cnt, vs_cnt, fs_cnt;

    initial begin
        reset_n = 1'b0;
        drive_random();
        n_clk = 0;

        // Reset held for 3 clocks
        for (int i = 0; i < 3; i++) step(1'b0);

        // Run just over one frame, counting sync widths and frame pulses
        hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 2 * HT * VT + 60; i++) begin
            step(1'b1);
            if (n_clk <= 2 * HT + 10 && !hsync) hs_cnt++;
            if (!vsync) vs_cnt++;
            if (frame_start) fs_cnt++;
        end
        check("hsync_low_clocks_line0", 32'(hs_cnt), 32'(2 * HS));
        check("vsync_low_clocks_frame", 32'(vs_cnt), 32'(2 * HS * 0 + 2 * VS * HT));
        check("frame_start_pulses", 32'(fs_cnt), 32'd1);

        // Mid-line reset for 3 clocks, then run two more frames
        for (int i = 0; i < 37; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 4 * HT * VT + 100; i++) step(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
